// File: rtl/result_pipe.sv
// Result staging pipe behind the SPU execute stage: DEPTH-stage shift pipe
// with RA/RB/RC forwarding and RAW stall detect; RESULT_FWD_EN enables the forward mux.
module result_pipe #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [ADDR_W-1:0]     rt_addr_EX,
   input  logic [DATA_W-1:0]     result_EX,
   input  logic [2:0]            latency_EX,
   input  logic                  flush,
   input  logic [2:0]            q_valid,
   input  logic [3*ADDR_W-1:0]   q_addr,
   output logic [2:0]            fwd_hit,
   output logic [3*DATA_W-1:0]   fwd_data,
   output logic                  fwd_stall,
   output logic                  wb_en,
   output logic [ADDR_W-1:0]     wb_addr,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  pipe_busy
);

   logic [DEPTH-1:0]  st_valid;
   logic [ADDR_W-1:0] st_addr [DEPTH];
   logic [DATA_W-1:0] st_data [DEPTH];

`ifdef RESULT_FWD_EN
   localparam int LMAX = DEPTH - 1;

   logic [2:0]       st_lat [DEPTH];
   logic [2:0]       lat_in;
   logic [DEPTH-1:0] st_done;

   assign lat_in = (int'(latency_EX) > LMAX) ? 3'(LMAX) : latency_EX;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) st_lat[k] <= '0;
      end else begin
         st_lat[0] <= lat_in;
         for (int k = 1; k < DEPTH; k++) st_lat[k] <= st_lat[k-1];
      end
   end

   always_comb begin
      st_done = '0;
      for (int k = 0; k < DEPTH; k++)
         st_done[k] = st_valid[k] && (int'(st_lat[k]) <= k);
   end

   // Scan oldest to youngest so the youngest match overwrites.
   always_comb begin
      logic             found;
      logic             done;
      logic [DATA_W-1:0] data;
      fwd_hit   = '0;
      fwd_data  = '0;
      fwd_stall = 1'b0;
      for (int q = 0; q < 3; q++) begin
         found = 1'b0;
         done  = 1'b0;
         data  = '0;
         for (int k = DEPTH-1; k >= 0; k--) begin
            if (st_valid[k] &&
                st_addr[k] == q_addr[q*ADDR_W +: ADDR_W]) begin
               found = 1'b1;
               done  = st_done[k];
               data  = st_data[k];
            end
         end
         if (q_valid[q]) begin
            fwd_hit[q] = found && done;
            if (found && done)
               fwd_data[q*DATA_W +: DATA_W] = data;
            fwd_stall = fwd_stall | (found && !done);
         end
      end
   end
`else
   logic unused_lat;
   assign unused_lat = ^latency_EX;
   assign fwd_hit    = '0;
   assign fwd_data   = '0;

   // Without forwarding, any in-flight producer blocks until writeback.
   always_comb begin
      fwd_stall = 1'b0;
      for (int q = 0; q < 3; q++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (q_valid[q] && st_valid[k] &&
                st_addr[k] == q_addr[q*ADDR_W +: ADDR_W])
               fwd_stall = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_valid <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            st_addr[k] <= '0;
            st_data[k] <= '0;
         end
      end else begin
         st_valid   <= flush ? '0 : {st_valid[DEPTH-2:0], in_valid};
         st_addr[0] <= rt_addr_EX;
         st_data[0] <= result_EX;
         for (int k = 1; k < DEPTH; k++) begin
            st_addr[k] <= st_addr[k-1];
            st_data[k] <= st_data[k-1];
         end
      end
   end

   assign wb_en     = st_valid[DEPTH-1];
   assign wb_addr   = wb_en ? st_addr[DEPTH-1] : '0;
   assign wb_data   = wb_en ? st_data[DEPTH-1] : '0;
   assign pipe_busy = |st_valid;

endmodule

// File: tb/tb_result_pipe.sv
// Scoreboard bench for result_pipe: writebacks are checked by a monitor
// against an expected queue; forwarding and stall are checked with directed vectors.
module tb_result_pipe;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 128;
`ifdef RESULT_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic [ADDR_W-1:0]   rt_addr_EX = '0;
   logic [DATA_W-1:0]   result_EX = '0;
   logic [2:0]          latency_EX = '0;
   logic                flush = 1'b0;
   logic [2:0]          q_valid = '0;
   logic [3*ADDR_W-1:0] q_addr = '0;
   logic [2:0]          fwd_hit;
   logic [3*DATA_W-1:0] fwd_data;
   logic                fwd_stall;
   logic                wb_en;
   logic [ADDR_W-1:0]   wb_addr;
   logic [DATA_W-1:0]   wb_data;
   logic                pipe_busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];

   result_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .rt_addr_EX(rt_addr_EX), .result_EX(result_EX),
      .latency_EX(latency_EX), .flush(flush),
      .q_valid(q_valid), .q_addr(q_addr),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .pipe_busy(pipe_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [383:0] act,
                      input logic [383:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one result across one edge; push it when a writeback is due.
   task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [2:0] l, input bit push);
      in_valid   = 1'b1;
      rt_addr_EX = a;
      result_EX  = d;
      latency_EX = l;
      if (push) exp_q.push_back({a, d});
      tick(1);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [ADDR_W+DATA_W-1:0] e;
      if (rst_n && wb_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_unexpected: got addr %0d data %0h, required no write",
                     wb_addr, wb_data);
         end else begin
            e = exp_q.pop_front();
            chk("wb_addr", 384'(wb_addr), 384'(e[ADDR_W+DATA_W-1:DATA_W]));
            chk("wb_data", 384'(wb_data), 384'(e[DATA_W-1:0]));
         end
      end
   end

   initial begin
      // reset state
      tick(2);
      chk("rst_busy", 384'(pipe_busy), 384'(0));
      chk("rst_wb_en", 384'(wb_en), 384'(0));
      chk("rst_wb_data", 384'(wb_data), 384'(0));
      chk("rst_stall", 384'(fwd_stall), 384'(0));
      chk("rst_fwd", fwd_data, 384'(0));
      rst_n = 1'b1;
      tick(1);

      // writeback timing, stall then forward
      q_valid = 3'b001;
      q_addr  = '0;
      q_addr[6:0] = 7'd5;
      issue(7'd5, 128'h1234, 3'd2, 1'b1);
      for (int e = 0; e <= 8; e++) begin
         chk($sformatf("t1_busy_e%0d", e), 384'(pipe_busy), 384'(e <= 7));
         chk($sformatf("t1_wben_e%0d", e), 384'(wb_en), 384'(e == 7));
         chk($sformatf("t1_stall_e%0d", e), 384'(fwd_stall),
             384'(FWD ? (e < 2) : (e <= 7)));
         chk($sformatf("t1_hit_e%0d", e), 384'(fwd_hit),
             384'((FWD && e >= 2 && e <= 7) ? 3'b001 : 3'b000));
         chk($sformatf("t1_data_e%0d", e), 384'(fwd_data[127:0]),
             384'((FWD && e >= 2 && e <= 7) ? 128'h1234 : 128'h0));
         if (e < 8) tick(1);
      end

      // youngest wins, in-order writeback
      q_valid = 3'b000;
      issue(7'd9, 128'hA, 3'd0, 1'b1);
      issue(7'd9, 128'hB, 3'd0, 1'b1);
      q_valid = 3'b010;
      q_addr  = '0;
      q_addr[13:7] = 7'd9;
      #1;
      chk("yw_hit", 384'(fwd_hit), 384'(FWD ? 3'b010 : 3'b000));
      chk("yw_data", 384'(fwd_data[255:128]), 384'(FWD ? 128'hB : 128'h0));
      chk("yw_stall", 384'(fwd_stall), 384'(!FWD));
      q_valid = 3'b000;
      tick(9);
      chk("yw_drain_busy", 384'(pipe_busy), 384'(0));
      chk("yw_drain_q", 384'(exp_q.size()), 384'(0));

      // flush beats a same-edge capture
      for (int i = 0; i < 4; i++) issue(7'(10 + i), 128'(32'hF00 + i), 3'd1, 1'b0);
      flush      = 1'b1;
      in_valid   = 1'b1;
      rt_addr_EX = 7'd3;
      result_EX  = 128'h33;
      tick(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      q_valid  = 3'b111;
      q_addr   = {7'd3, 7'd13, 7'd10};
      #1;
      chk("fl_busy", 384'(pipe_busy), 384'(0));
      chk("fl_hit", 384'(fwd_hit), 384'(0));
      chk("fl_stall", 384'(fwd_stall), 384'(0));
      chk("fl_data", fwd_data, 384'(0));
      tick(10);

      // asynchronous reset mid-operation
      q_valid = 3'b001;
      q_addr  = {7'd0, 7'd0, 7'd21};
      for (int i = 0; i < 3; i++) issue(7'(20 + i), 128'(32'hC00 + i), 3'd0, 1'b0);
      chk("ar_pre_busy", 384'(pipe_busy), 384'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_busy", 384'(pipe_busy), 384'(0));
      chk("ar_wben", 384'(wb_en), 384'(0));
      chk("ar_stall", 384'(fwd_stall), 384'(0));
      chk("ar_hit", 384'(fwd_hit), 384'(0));
      #1;
      rst_n   = 1'b1;
      q_valid = 3'b000;
      tick(10);

      // mixed latency, three queries
      issue(7'd1, 128'h11, 3'd0, 1'b1);
      issue(7'd2, 128'h22, 3'd6, 1'b1);
      issue(7'd3, 128'h33, 3'd6, 1'b1);
      tick(2);
      q_valid = 3'b111;
      q_addr  = {7'd4, 7'd2, 7'd1};
      #1;
      chk("mx_hit", 384'(fwd_hit), 384'(FWD ? 3'b001 : 3'b000));
      chk("mx_stall", 384'(fwd_stall), 384'(1));
      chk("mx_data_ra", 384'(fwd_data[127:0]), 384'(FWD ? 128'h11 : 128'h0));
      chk("mx_data_rc", 384'(fwd_data[383:256]), 384'(0));
      q_valid = 3'b000;
      tick(3);
      q_valid = 3'b010;
      #1;
      chk("mx6_hit", 384'(fwd_hit), 384'(FWD ? 3'b010 : 3'b000));
      chk("mx6_data", 384'(fwd_data[255:128]), 384'(FWD ? 128'h22 : 128'h0));
      chk("mx6_stall", 384'(fwd_stall), 384'(!FWD));
      q_valid = 3'b000;
      tick(10);

      chk("sb_empty", 384'(exp_q.size()), 384'(0));
      chk("end_busy", 384'(pipe_busy), 384'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
